// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between instruction fetch and
// load/store. Data-first priority, one grant per cycle, read responses routed
// back to their owner one cycle after the grant.
// Optional feature: define MEMARB_STARVE_GUARD_EN to force a fetch grant after
// MAX_WAIT consecutive denied fetch cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // Load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnD} own_e;

  own_e rsp_own_q, rsp_own_d;
  logic force_if;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic [WaitW-1:0] wait_cnt_q;

  assign force_if = if_req && (wait_cnt_q == WaitW'(MAX_WAIT));

  // Count consecutive denied fetch cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (if_gnt || !if_req) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != WaitW'(MAX_WAIT)) begin
      wait_cnt_q <= wait_cnt_q + WaitW'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grant decode: data first unless the fetch is being forced; nothing during reset.
  always_comb begin
    d_gnt  = reset & d_req & ~force_if;
    if_gnt = reset & if_req & (~d_req | force_if);
  end

  // Steer the granted requester onto the memory port; all zero when idle.
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr[MEM_AW+1:2];
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr[MEM_AW+1:2];
    end
  end

  // Next response owner: stores produce no response.
  always_comb begin
    rsp_own_d = OwnNone;
    if (if_gnt) begin
      rsp_own_d = OwnIf;
    end else if (d_gnt && !d_we) begin
      rsp_own_d = OwnD;
    end
  end

  // Response owner register; reset drops any outstanding read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_own_q <= OwnNone;
    end else begin
      rsp_own_q <= rsp_own_d;
    end
  end

  // Read data passes straight through; the valid flags say who owns it.
  always_comb begin
    if_rvalid = (rsp_own_q == OwnIf);
    d_rvalid  = (rsp_own_q == OwnD);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

  // Byte-offset and wrap-around address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                              d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a synchronous memory model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MEM_AW = 12;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_AW  (MEM_AW),
    .MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory, read-before-write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive new inputs just after the falling edge; checks follow #1 later.
  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd);
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic exp_if_gnt;
  logic prev_if_gnt;
  logic prev_d_gnt;

  initial begin
    for (int i = 0; i < 2**MEM_AW; i++) mem[i] = '0;
    mem[2]    = 32'h2008_0005;
    mem[2049] = 32'hdead_beef;
    mem_rdata = '0;

    // Reset hold with both requests up
    reset   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h8;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h2004;
    d_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    end

    // Release: data granted on the first cycle
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_d_gnt", 32'(d_gnt), 32'd1);
    check("rel_if_gnt", 32'(if_gnt), 32'd0);
    check("rel_mem_en", 32'(mem_en), 32'd1);
    check("rel_mem_we", 32'(mem_we), 32'd0);
    check("rel_mem_addr", 32'(mem_addr), 32'd2049);

    idle();
    check("rel_d_rvalid", 32'(d_rvalid), 32'd1);
    check("rel_d_rdata", d_rdata, 32'hdead_beef);
    check("rel_if_rvalid", 32'(if_rvalid), 32'd0);
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("idle_mem_addr", 32'(mem_addr), 32'd0);

    // Fetch read
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    check("fetch_if_gnt", 32'(if_gnt), 32'd1);
    check("fetch_d_gnt", 32'(d_gnt), 32'd0);
    check("fetch_mem_addr", 32'(mem_addr), 32'd2);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    idle();
    check("fetch_if_rvalid", 32'(if_rvalid), 32'd1);
    check("fetch_if_rdata", if_rdata, 32'h2008_0005);
    check("fetch_d_rvalid", 32'(d_rvalid), 32'd0);

    // Store then load at the same address
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'd48);
    check("st_d_gnt", 32'(d_gnt), 32'd1);
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_mem_addr", 32'(mem_addr), 32'd2048);
    check("st_mem_wdata", mem_wdata, 32'd48);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'd0);
    check("ld_mem_we", 32'(mem_we), 32'd0);
    check("st_no_rvalid", 32'(d_rvalid), 32'd0);
    idle();
    check("ld_d_rvalid", 32'(d_rvalid), 32'd1);
    check("ld_d_rdata", d_rdata, 32'd48);

    // Contention: data first, then fetch; responses in grant order
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h2000, 32'd0);
    check("cont_d_gnt", 32'(d_gnt), 32'd1);
    check("cont_if_gnt", 32'(if_gnt), 32'd0);
    check("cont_mem_addr", 32'(mem_addr), 32'd2048);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'd0);
    check("cont2_if_gnt", 32'(if_gnt), 32'd1);
    check("cont2_mem_addr", 32'(mem_addr), 32'd2);
    check("cont2_d_rvalid", 32'(d_rvalid), 32'd1);
    check("cont2_d_rdata", d_rdata, 32'd48);
    check("cont2_if_rvalid", 32'(if_rvalid), 32'd0);
    idle();
    check("cont3_if_rvalid", 32'(if_rvalid), 32'd1);
    check("cont3_if_rdata", if_rdata, 32'h2008_0005);
    check("cont3_d_rvalid", 32'(d_rvalid), 32'd0);

    // Address wrap and ignored byte offset
    drive(1'b1, 32'hffff_4009, 1'b0, 1'b0, 32'h0, 32'd0);
    check("wrap_mem_addr", 32'(mem_addr), 32'd2);
    idle();
    check("wrap_if_rdata", if_rdata, 32'h2008_0005);

    // Both requests held continuously
    prev_if_gnt = 1'b0;
    prev_d_gnt  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h2000, 32'd0);
`ifdef MEMARB_STARVE_GUARD_EN
      exp_if_gnt = ((k % 5) == 4);
`else
      exp_if_gnt = 1'b0;
`endif
      check("starve_if_gnt", 32'(if_gnt), 32'(exp_if_gnt));
      check("starve_d_gnt", 32'(d_gnt), 32'(!exp_if_gnt));
      check("starve_if_rvalid", 32'(if_rvalid), 32'(prev_if_gnt));
      check("starve_d_rvalid", 32'(d_rvalid), 32'(prev_d_gnt));
      prev_if_gnt = exp_if_gnt;
      prev_d_gnt  = !exp_if_gnt;
    end
    idle();
    idle();

    // Reset in the cycle after a fetch grant drops the response
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'd0);
    check("mid_if_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk);
    if_req = 1'b0;
    reset  = 1'b0;
    #1;
    check("mid_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rel_if_rvalid", 32'(if_rvalid), 32'd0);
    idle();
    check("mid_post_if_rvalid", 32'(if_rvalid), 32'd0);
    check("mid_post_d_rvalid", 32'(d_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
